// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add MUL,
// NZCV + illegal flags, valid/ready on both sides; accepts only in IDLE, holds result in DONE.
module alu_mc #(
   parameter int N  = 64,
   parameter int SW = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   ALUControl,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         zero,
   output logic         negative,
   output logic         carry,
   output logic         overflow,
   output logic         illegal
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_LSL  = 4'b1000;
   localparam logic [3:0] OP_LSR  = 4'b1001;
   localparam logic [3:0] OP_MUL  = 4'b1010;

   // EXEC is the single evaluation cycle of non-MUL ops after operands are latched.
   typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [3:0]    op_q, op_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [N-1:0]  result_q, result_d;
   logic          zero_q, zero_d;
   logic          negative_q, negative_d;
   logic          carry_q, carry_d;
   logic          overflow_q, overflow_d;
   logic          illegal_q, illegal_d;
   logic          out_valid_q, out_valid_d;
   logic          in_ready_q, in_ready_d;

   logic [N:0]    sum, diff;
   logic          shift_big;
   logic [SW-1:0] sh;
   logic [N-1:0]  ex_res;
   logic          ex_c, ex_v, ex_ill;
   logic [N-1:0]  acc_nxt;
   logic          load;
   logic [N-1:0]  new_res;
   logic          new_c, new_v, new_ill;

   always_comb begin
      sum       = {1'b0, a_q} + {1'b0, b_q};
      diff      = {1'b0, a_q} + {1'b0, ~b_q} + {{N{1'b0}}, 1'b1};
      shift_big = (b_q >> SW) != '0;
      sh        = b_q[SW-1:0];
      ex_res    = '0;
      ex_c      = 1'b0;
      ex_v      = 1'b0;
      ex_ill    = 1'b0;
      case (op_q)
         OP_AND:  ex_res = a_q & b_q;
         OP_OR:   ex_res = a_q | b_q;
         OP_ADD: begin
            ex_res = sum[N-1:0];
            ex_c   = sum[N];
            ex_v   = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
         end
         OP_SUB: begin
            ex_res = diff[N-1:0];
            ex_c   = diff[N];
            ex_v   = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
         end
         OP_PASS: ex_res = b_q;
         OP_LSL:  ex_res = shift_big ? '0 : (a_q << sh);
         OP_LSR:  ex_res = shift_big ? '0 : (a_q >> sh);
         default: ex_ill = 1'b1;
      endcase
   end

   // Multiplicand shifts left and multiplier right each step, so bit 0 of b_q is the current bit.
   assign acc_nxt = acc_q + (b_q[0] ? a_q : '0);

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      load        = 1'b0;
      new_res     = '0;
      new_c       = 1'b0;
      new_v       = 1'b0;
      new_ill     = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = ALUControl;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = (ALUControl == OP_MUL) ? MUL : EXEC;
            end
         end
         EXEC: begin
            load        = 1'b1;
            new_res     = ex_res;
            new_c       = ex_c;
            new_v       = ex_v;
            new_ill     = ex_ill;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         MUL: begin
            acc_d = acc_nxt;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + SW'(1);
            if (cnt_q == SW'(N - 1)) begin
               load        = 1'b1;
               new_res     = acc_nxt;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Result and flags only move on entry to DONE.
      result_d   = load ? new_res : result_q;
      zero_d     = load ? (new_res == '0) : zero_q;
      negative_d = load ? new_res[N-1] : negative_q;
      carry_d    = load ? new_c : carry_q;
      overflow_d = load ? new_v : overflow_q;
      illegal_d  = load ? new_ill : illegal_q;
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         negative_q  <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         negative_q  <= negative_d;
         carry_q     <= carry_d;
         overflow_q  <= overflow_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign negative  = negative_q;
   assign carry     = carry_q;
   assign overflow  = overflow_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: 64-bit and 8-bit instances, directed vectors.
module tb_alu_mc;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  f;     // {zero, negative, carry, overflow, illegal}
      int          lat;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t q64[$];
   exp_t q8[$];
   logic seen64 = 1'b0;
   logic seen8  = 1'b0;

   // 64-bit instance
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [63:0] a, b, result;
   logic [3:0]  ALUControl;
   logic        zero, negative, carry, overflow, illegal;

   alu_mc #(.N(64)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ALUControl(ALUControl), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .negative(negative), .carry(carry),
      .overflow(overflow), .illegal(illegal)
   );

   // 8-bit instance
   logic       in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0] a8, b8, result8;
   logic [3:0] alu_ctl8;
   logic       zero8, negative8, carry8, overflow8, illegal8;

   alu_mc #(.N(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .ALUControl(alu_ctl8), .out_valid(out_valid8), .out_ready(out_ready8),
      .result(result8), .zero(zero8), .negative(negative8), .carry(carry8),
      .overflow(overflow8), .illegal(illegal8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : mon64
      exp_t e;
      if (out_valid) begin
         if (q64.size() == 0) begin
            check("out_valid_without_pending_op64", {63'd0, out_valid}, 64'd0);
         end else begin
            e = q64[0];
            check("result64", result, e.res);
            check("flags64", {59'd0, zero, negative, carry, overflow, illegal}, {59'd0, e.f});
            check("in_ready_while_done64", {63'd0, in_ready}, 64'd0);
            if (!seen64) begin
               check("latency64", 64'(cyc - e.acc), 64'(e.lat));
               seen64 = 1'b1;
            end
            if (out_ready) begin
               void'(q64.pop_front());
               seen64 = 1'b0;
            end
         end
      end else if (q64.size() != 0) begin
         check("in_ready_while_busy64", {63'd0, in_ready}, 64'd0);
      end
   end

   always @(negedge clk) begin : mon8
      exp_t e;
      if (out_valid8) begin
         if (q8.size() == 0) begin
            check("out_valid_without_pending_op8", {63'd0, out_valid8}, 64'd0);
         end else begin
            e = q8[0];
            check("result8", {56'd0, result8}, e.res);
            check("flags8", {59'd0, zero8, negative8, carry8, overflow8, illegal8}, {59'd0, e.f});
            if (!seen8) begin
               check("latency8", 64'(cyc - e.acc), 64'(e.lat));
               seen8 = 1'b1;
            end
            if (out_ready8) begin
               void'(q8.pop_front());
               seen8 = 1'b0;
            end
         end
      end else if (q8.size() != 0) begin
         check("in_ready_while_busy8", {63'd0, in_ready8}, 64'd0);
      end
   end

   task automatic issue64(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] r_exp, input logic [4:0] f_exp, input int lat);
      int k = 0;
      @(negedge clk);
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("in_ready_before_issue64", {63'd0, in_ready}, 64'd1);
      in_valid   = 1'b1;
      ALUControl = op;
      a          = av;
      b          = bv;
      @(posedge clk);
      #1;
      q64.push_back('{res: r_exp, f: f_exp, lat: lat, acc: cyc});
      in_valid = 1'b0;
   endtask

   task automatic issue8(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] r_exp, input logic [4:0] f_exp, input int lat);
      int k = 0;
      @(negedge clk);
      while (!in_ready8 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("in_ready_before_issue8", {63'd0, in_ready8}, 64'd1);
      in_valid8 = 1'b1;
      alu_ctl8  = op;
      a8        = av;
      b8        = bv;
      @(posedge clk);
      #1;
      q8.push_back('{res: {56'd0, r_exp}, f: f_exp, lat: lat, acc: cyc});
      in_valid8 = 1'b0;
   endtask

   task automatic drain;
      int k = 0;
      while ((q64.size() != 0 || q8.size() != 0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (q64.size() != 0 || q8.size() != 0) begin
         check("drain_timeout", 64'(q64.size() + q8.size()), 64'd0);
         q64.delete();
         q8.delete();
      end
   endtask

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
   localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

   initial begin
      int k;
      reset      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      a          = '0;
      b          = '0;
      ALUControl = '0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      a8         = '0;
      b8         = '0;
      alu_ctl8   = '0;

      repeat (3) @(negedge clk);
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_result", result, 64'd0);
      check("reset_flags", {59'd0, zero, negative, carry, overflow, illegal}, 64'd0);
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      reset = 1'b0;

      // flags vector: {zero, negative, carry, overflow, illegal}
      issue64(4'b0010, ONES, 64'd1, 64'd0, 5'b10100, 1);                 drain();
      issue64(4'b0110, ONES, 64'd1, ONES - 64'd1, 5'b01100, 1);          drain();
      issue64(4'b0010, MAXP, MAXP, ONES - 64'd1, 5'b01010, 1);           drain();
      issue64(4'b0010, MSB, MSB, 64'd0, 5'b10110, 1);                    drain();
      issue64(4'b0110, 64'd0, 64'd1, ONES, 5'b01000, 1);                 drain();
      issue64(4'b0110, 64'd5, 64'd5, 64'd0, 5'b10100, 1);                drain();
      issue64(4'b1000, 64'hFFFF, 64'd16, 64'hFFFF_0000, 5'b00000, 1);    drain();
      issue64(4'b1001, MSB, 64'd63, 64'd1, 5'b00000, 1);                 drain();
      issue64(4'b1000, 64'hFFFF, 64'd64, 64'd0, 5'b10000, 1);            drain();
      issue64(4'b1000, 64'hFFFE, 64'd63, 64'd0, 5'b10000, 1);            drain();
      issue64(4'b1001, ONES, MSB | 64'd1, 64'd0, 5'b10000, 1);           drain();
      issue64(4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 5'b00000, 1);       drain();
      issue64(4'b0111, 64'h1234, MSB, MSB, 5'b01000, 1);                 drain();
      issue64(4'b1010, 64'd12345, 64'd1000, 64'd12345000, 5'b00000, 64); drain();
      issue64(4'b1010, ONES, ONES, 64'd1, 5'b00000, 64);                 drain();
      issue64(4'b1111, 64'd7, 64'd9, 64'd0, 5'b10001, 1);                drain();
      issue64(4'b0011, 64'd7, 64'd9, 64'd0, 5'b10001, 1);                drain();

      // Backpressure: OR result held 5 cycles while a competing in_valid is ignored.
      @(posedge clk);
      #1 out_ready = 1'b0;
      issue64(4'b0001, 64'h00FF, 64'hFF00, 64'hFFFF, 5'b00000, 1);
      k = 0;
      while (!out_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("backpressure_out_valid", {63'd0, out_valid}, 64'd1);
      in_valid   = 1'b1;
      ALUControl = 4'b0010;
      a          = 64'd1;
      b          = 64'd2;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 check("in_ready_after_release", {63'd0, in_ready}, 64'd1);
      drain();
      repeat (5) @(negedge clk);

      // Reset at cycle 10 of a MUL.
      issue64(4'b1010, 64'd12345, 64'd1000, 64'd12345000, 5'b00000, 64);
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      q64.delete();
      seen64 = 1'b0;
      #1;
      check("midmul_reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("midmul_reset_result", result, 64'd0);
      check("midmul_reset_flags", {59'd0, zero, negative, carry, overflow, illegal}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
      repeat (70) @(negedge clk);
      issue64(4'b0010, 64'd100, 64'd200, 64'd300, 5'b00000, 1);         drain();

      // 8-bit instance.
      issue8(4'b1010, 8'h10, 8'h10, 8'h00, 5'b10000, 8);                 drain();
      issue8(4'b1010, 8'hFF, 8'h03, 8'hFD, 5'b01000, 8);                 drain();
      issue8(4'b0010, 8'h7F, 8'h01, 8'h80, 5'b01010, 1);                 drain();
      issue8(4'b1000, 8'h01, 8'h08, 8'h00, 5'b10000, 1);                 drain();
      issue8(4'b1001, 8'h80, 8'h07, 8'h01, 5'b00000, 1);                 drain();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
